// File: rtl/cfg_lyr_sequencer.sv
// Layer sequencer for an N-layer 1-D CNN: fetches one parameter word per layer,
// then walks kernel taps and output columns to drive feature/weight buffer addresses.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting the layer parameter word
// CAL   | issuing one kernel tap per cycle
// WAIT  | waiting for PE array completion
// NEXT  | advance layer or finish
// DONE  | all_done pulse, then back to IDLE
module cfg_lyr_sequencer #(
  parameter int N_CH   = 8,
  parameter int N_LYR  = 16,
  parameter int ADDR_W = 13,
  parameter int WT_AW  = 11,
  parameter int CYC_W  = 11,
  localparam int LW    = (N_LYR > 1) ? $clog2(N_LYR) : 1,
  localparam int CC_W  = CYC_W + 8
) (
  input  logic              clk_cal,
  input  logic              rst_cal,
  input  logic              start,
  input  logic [LW:0]       lyr_num,
  input  logic              abort,
  input  logic              prm_vld,
  input  logic [31:0]       prm_data,
  output logic              prm_rdy,
  input  logic              pe_end,
  output logic              busy,
  output logic [2:0]        state,
  output logic [LW-1:0]     nn_layer_cnt,
  output logic [7:0]        K,
  output logic [7:0]        S,
  output logic [2:0]        Pool_K,
  output logic [1:0]        Pool_S,
  output logic [CC_W-1:0]   cal_cycle,
  output logic              rd_vld,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_bank,
  output logic [WT_AW-1:0]  wt_addr,
  output logic [N_CH-1:0]   wt_O_vld,
  output logic              final_column,
  output logic              lyr_done,
  output logic              all_done
);

  localparam int CB_W = ADDR_W - 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CAL  = 3'd2,
    S_WAIT = 3'd3,
    S_NEXT = 3'd4,
    S_DONE = 3'd5
  } st_t;

  st_t st, st_nxt;

  logic [LW:0]      lyr_max;
  logic [7:0]       k_eff, s_eff, tap;
  logic [CYC_W-1:0] len_eff, col;
  logic [CB_W-1:0]  col_base;
  logic             pe_seen;
  logic             last_tap, last_col, last_lyr;
  logic [7:0]       k_in, s_in;
  logic [CYC_W-1:0] len_in;

  assign k_in   = (prm_data[7:0] == 8'd0) ? 8'd1 : prm_data[7:0];
  assign s_in   = (prm_data[15:8] == 8'd0) ? 8'd1 : prm_data[15:8];
  assign len_in = (prm_data[31:21] == 11'd0) ? CYC_W'(1) : CYC_W'(prm_data[31:21]);

  assign last_tap = (tap == k_eff - 8'd1);
  assign last_col = (col == len_eff - CYC_W'(1));
  assign last_lyr = ({1'b0, nn_layer_cnt} == lyr_max - (LW+1)'(1));

  assign busy  = (st != S_IDLE);
  assign state = st;

  always_ff @(posedge clk_cal or posedge rst_cal) begin
    if (rst_cal) st <= S_IDLE;
    else         st <= st_nxt;
  end

  always_comb begin
    st_nxt   = st;
    prm_rdy  = 1'b0;
    lyr_done = 1'b0;
    all_done = 1'b0;
    case (st)
      S_IDLE: if (start) st_nxt = S_LOAD;
      S_LOAD: begin
        prm_rdy = 1'b1;
        if (prm_vld) st_nxt = S_CAL;
      end
      S_CAL:  if (last_tap && last_col) st_nxt = S_WAIT;
      S_WAIT: if (pe_end || pe_seen) st_nxt = S_NEXT;
      S_NEXT: begin
        if (last_lyr) st_nxt = S_DONE;
        else begin
          st_nxt   = S_LOAD;
          lyr_done = 1'b1;
        end
      end
      S_DONE: begin
        all_done = 1'b1;
        st_nxt   = S_IDLE;
      end
      default: st_nxt = S_IDLE;
    endcase
    // abort wins over everything, including a handshake in the same cycle
    if (abort) begin
      st_nxt   = S_IDLE;
      prm_rdy  = 1'b0;
      lyr_done = 1'b0;
      all_done = 1'b0;
    end
  end

  always_ff @(posedge clk_cal or posedge rst_cal) begin
    if (rst_cal) begin
      lyr_max      <= '0;
      nn_layer_cnt <= '0;
      K            <= '0;
      S            <= '0;
      Pool_K       <= '0;
      Pool_S       <= '0;
      k_eff        <= '0;
      s_eff        <= '0;
      len_eff      <= '0;
      cal_cycle    <= '0;
      wr_bank      <= 1'b0;
      tap          <= '0;
      col          <= '0;
      col_base     <= '0;
      pe_seen      <= 1'b0;
      rd_vld       <= 1'b0;
      rd_addr      <= '0;
      wt_addr      <= '0;
      wt_O_vld     <= '0;
      final_column <= 1'b0;
    end else begin
      rd_vld       <= 1'b0;
      wt_O_vld     <= '0;
      final_column <= 1'b0;
      if (abort) begin
        nn_layer_cnt <= '0;
        tap          <= '0;
        col          <= '0;
        col_base     <= '0;
        pe_seen      <= 1'b0;
      end else begin
        case (st)
          S_IDLE: if (start) begin
            lyr_max      <= (lyr_num == '0) ? (LW+1)'(1) : lyr_num;
            nn_layer_cnt <= '0;
          end
          S_LOAD: if (prm_vld) begin
            K         <= prm_data[7:0];
            S         <= prm_data[15:8];
            Pool_K    <= prm_data[18:16];
            Pool_S    <= prm_data[20:19];
            k_eff     <= k_in;
            s_eff     <= s_in;
            len_eff   <= len_in;
            cal_cycle <= CC_W'(len_in) * CC_W'(k_in);
            wr_bank   <= ~nn_layer_cnt[0];
            tap       <= '0;
            col       <= '0;
            col_base  <= '0;
            pe_seen   <= 1'b0;
          end
          S_CAL: begin
            rd_vld       <= 1'b1;
            wt_O_vld     <= '1;
            rd_addr      <= {nn_layer_cnt[0], col_base + CB_W'(tap)};
            wt_addr      <= WT_AW'(tap);
            final_column <= last_col;
            if (pe_end) pe_seen <= 1'b1;
            if (last_tap) begin
              tap      <= '0;
              col      <= col + CYC_W'(1);
              col_base <= col_base + CB_W'(s_eff);
            end else begin
              tap <= tap + 8'd1;
            end
          end
          S_NEXT: if (!last_lyr) nn_layer_cnt <= nn_layer_cnt + LW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfg_lyr_sequencer.sv
// Self-checking bench for cfg_lyr_sequencer: scoreboard of expected read
// transactions filled at each parameter handshake, drained by a read monitor.
module tb_cfg_lyr_sequencer;

  logic        clk_cal = 1'b0;
  logic        rst_cal = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  lyr_num = '0;
  logic        abort = 1'b0;
  logic        prm_vld = 1'b0;
  logic [31:0] prm_data = '0;
  logic        prm_rdy;
  logic        pe_end = 1'b0;
  logic        busy;
  logic [2:0]  state;
  logic [3:0]  nn_layer_cnt;
  logic [7:0]  K, S;
  logic [2:0]  Pool_K;
  logic [1:0]  Pool_S;
  logic [18:0] cal_cycle;
  logic        rd_vld;
  logic [12:0] rd_addr;
  logic        wr_bank;
  logic [10:0] wt_addr;
  logic [7:0]  wt_O_vld;
  logic        final_column;
  logic        lyr_done;
  logic        all_done;

  cfg_lyr_sequencer dut (
    .clk_cal(clk_cal), .rst_cal(rst_cal), .start(start), .lyr_num(lyr_num),
    .abort(abort), .prm_vld(prm_vld), .prm_data(prm_data), .prm_rdy(prm_rdy),
    .pe_end(pe_end), .busy(busy), .state(state), .nn_layer_cnt(nn_layer_cnt),
    .K(K), .S(S), .Pool_K(Pool_K), .Pool_S(Pool_S), .cal_cycle(cal_cycle),
    .rd_vld(rd_vld), .rd_addr(rd_addr), .wr_bank(wr_bank), .wt_addr(wt_addr),
    .wt_O_vld(wt_O_vld), .final_column(final_column), .lyr_done(lyr_done),
    .all_done(all_done)
  );

  always #5 clk_cal = ~clk_cal;

  typedef struct {
    logic [12:0] addr;
    logic [10:0] wt;
    logic        fc;
  } rd_t;

  rd_t q[$];
  int  n_chk = 0, n_pass = 0;
  int  n_ld = 0, n_ad = 0, n_rdy_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  function automatic int eff_k(input logic [31:0] w);
    return (w[7:0] == 0) ? 1 : int'(w[7:0]);
  endfunction
  function automatic int eff_s(input logic [31:0] w);
    return (w[15:8] == 0) ? 1 : int'(w[15:8]);
  endfunction
  function automatic int eff_len(input logic [31:0] w);
    return (w[31:21] == 0) ? 1 : int'(w[31:21]);
  endfunction

  function automatic void push_layer(input int li, input logic [31:0] w);
    int k, s, len;
    rd_t e;
    k = eff_k(w); s = eff_s(w); len = eff_len(w);
    for (int c = 0; c < len; c++)
      for (int t = 0; t < k; t++) begin
        e.addr[12]   = li[0];
        e.addr[11:0] = 12'((c * s + t) % 4096);
        e.wt         = 11'(t);
        e.fc         = (c == len - 1);
        q.push_back(e);
      end
  endfunction

  always @(negedge clk_cal) begin
    if (!rst_cal) begin
      if (rd_vld) begin
        if (q.size() == 0) chk("rd_unexpected", q.size(), 1);
        else begin
          rd_t e;
          e = q.pop_front();
          chk("rd_addr", rd_addr, e.addr);
          chk("wt_addr", wt_addr, e.wt);
          chk("final_col", final_column, e.fc);
          chk("wt_vld", wt_O_vld, 8'hff);
        end
      end
      if (lyr_done) n_ld++;
      if (all_done) n_ad++;
      if (prm_rdy && state != 3'd1) n_rdy_bad++;
    end
  end

  task automatic tick();
    @(posedge clk_cal);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state != s && n < budget) begin
      tick();
      n++;
    end
    if (state != s) chk(tag, state, s);
  endtask

  task automatic run_net(input int nl, input logic [31:0] w, input int pe_dly,
                         input bit pe_in_cal, input int abort_lyr);
    int ld0, ad0, nle;
    ld0 = n_ld; ad0 = n_ad; n_rdy_bad = 0;
    nle = (nl == 0) ? 1 : nl;
    start = 1'b1; lyr_num = 5'(nl);
    tick();
    start = 1'b0;
    for (int i = 0; i < nle; i++) begin
      wait_state(3'd1, 20, "load_timeout");
      chk("lyr_cnt", nn_layer_cnt, i);
      chk("prm_rdy_load", prm_rdy, 1);
      prm_vld = 1'b1; prm_data = w;
      push_layer(i, w);
      tick();
      prm_vld = 1'b0;
      chk("cal_state", state, 3'd2);
      chk("rd_vld_lat", rd_vld, 0);
      chk("cal_cycle", cal_cycle, eff_len(w) * eff_k(w));
      chk("wr_bank", wr_bank, (i % 2) == 0);
      chk("pool_k", Pool_K, w[18:16]);
      chk("pool_s", Pool_S, w[20:19]);
      if (w[7:0] != 0) chk("k_reg", K, w[7:0]);
      if (w[15:8] != 0) chk("s_reg", S, w[15:8]);
      if (pe_in_cal) pe_end = 1'b1;
      tick();
      pe_end = 1'b0;
      chk("rd_vld_first", rd_vld, 1);
      wait_state(3'd3, 3000, "cal_timeout");
      if (i == abort_lyr) begin
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_idle", state, 3'd0);
        chk("abort_busy", busy, 0);
        chk("abort_rd_vld", rd_vld, 0);
        repeat (3) tick();
        chk("abort_stay_idle", state, 3'd0);
        chk("abort_no_all_done", n_ad - ad0, 0);
        chk("abort_lyr_done", n_ld - ld0, i);
        chk("abort_q", q.size(), 0);
        return;
      end
      if (!pe_in_cal) begin
        repeat (pe_dly) tick();
        chk("wait_hold", state, 3'd3);
        pe_end = 1'b1;
        tick();
        pe_end = 1'b0;
      end else begin
        tick();
      end
      chk("wait_exit", state, 3'd4);
    end
    wait_state(3'd0, 10, "done_timeout");
    chk("lyr_done_cnt", n_ld - ld0, nle - 1);
    chk("all_done_cnt", n_ad - ad0, 1);
    chk("final_lyr", nn_layer_cnt, nle - 1);
    chk("q_drained", q.size(), 0);
    chk("rdy_only_load", n_rdy_bad, 0);
  endtask

  localparam logic [31:0] W1   = {11'd4, 2'd1, 3'd2, 8'd2, 8'd3};
  localparam logic [31:0] WBIG = {11'd40, 2'd0, 3'd0, 8'd1, 8'd5};

  initial begin
    #2;
    chk("rst_state", state, 3'd0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_prm_rdy", prm_rdy, 0);
    tick();
    rst_cal = 1'b0;
    tick();

    run_net(1, W1, 5, 1'b0, -1);
    run_net(3, W1, 2, 1'b0, -1);
    run_net(2, W1, 0, 1'b1, -1);
    run_net(0, 32'd0, 1, 1'b0, -1);
    run_net(3, W1, 2, 1'b0, 1);
    run_net(1, W1, 1, 1'b0, -1);

    start = 1'b1; lyr_num = 5'd1;
    tick();
    start = 1'b0;
    wait_state(3'd1, 20, "load_timeout");
    prm_vld = 1'b1; prm_data = WBIG;
    push_layer(0, WBIG);
    tick();
    prm_vld = 1'b0;
    repeat (6) @(posedge clk_cal);
    #3 rst_cal = 1'b1;
    #1;
    chk("arst_state", state, 3'd0);
    chk("arst_busy", busy, 0);
    chk("arst_rd_vld", rd_vld, 0);
    chk("arst_rd_addr", rd_addr, 0);
    chk("arst_wt_vld", wt_O_vld, 0);
    chk("arst_k", K, 0);
    chk("arst_cal_cycle", cal_cycle, 0);
    q.delete();
    tick();
    rst_cal = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cfg_lyr_sequencer.md
Name: cfg_lyr_sequencer

Overview:
- Parametrised successor to the fixed 8-channel configurator control path.
- Sequences an N-layer 1-D CNN: fetches one parameter word per layer over a valid/ready stream, then generates feature-buffer read addresses and shared weight addresses for N_CH PE channels, one kernel tap per cycle.
- Waits for PE completion, then advances the layer and swaps ping-pong buffer banks.
- Sits between the SPI/MCU start logic and the PE array / InOutBuffer / Weight_Buffer.

Parameters:
- N_CH, 8, number of PE channels driven by wt_O_vld.
- N_LYR, 16, maximum layer count; LW = $clog2(N_LYR).
- ADDR_W, 13, feature-buffer address width; MSB is the ping-pong bank bit.
- WT_AW, 11, weight-buffer address width.
- CYC_W, 11, width of out_len and column counters.

Ports:
- clk_cal  in  1  calculation clock.
- rst_cal  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a network run.
- lyr_num  in  LW+1  number of layers (1..N_LYR), sampled on an accepted start.
- abort  in  1  synchronous; forces return to IDLE.
- prm_vld  in  1  parameter word valid.
- prm_data  in  32  [7:0] K, [15:8] S, [18:16] Pool_K, [20:19] Pool_S, [31:21] out_len.
- prm_rdy  out  1  parameter word ready.
- pe_end  in  1  PE array finished the current layer.
- busy  out  1  not IDLE.
- state  out  3  current FSM state.
- nn_layer_cnt  out  LW  current layer index.
- K, S  out  8 each  registered layer kernel size / stride.
- Pool_K  out  3  registered pooling size.
- Pool_S  out  2  registered pooling stride.
- cal_cycle  out  CYC_W+8  out_len*K_eff.
- rd_vld  out  1  read address valid.
- rd_addr  out  ADDR_W  feature read address.
- wr_bank  out  1  bank that layer outputs are written to.
- wt_addr  out  WT_AW  weight tap address.
- wt_O_vld  out  N_CH  per-channel weight valid.
- final_column  out  1  high during the taps of the last output column.
- lyr_done  out  1  one-cycle pulse per completed non-final layer.
- all_done  out  1  one-cycle pulse after the final layer.

Behaviour:
- Reset: all outputs and registers are 0; state=IDLE (0).
- State encoding: IDLE=0, LOAD=1, CAL=2, WAIT=3, NEXT=4, DONE=5.
- IDLE:
  - start accepted only here; start during any other state is ignored.
  - lyr_num is latched; lyr_num=0 is treated as 1.
  - nn_layer_cnt is cleared. Go to LOAD.
- LOAD:
  - prm_rdy=1 combinationally in this state only.
  - On prm_vld&prm_rdy: register all fields; K_eff = (K==0)?1:K; S_eff likewise; out_len=0 treated as 1.
  - Clear col, tap, col_base, pe_seen. Go to CAL next cycle.
  - prm_vld outside LOAD is ignored.
- CAL:
  - Every cycle: rd_vld=1 and wt_O_vld = all ones.
  - rd_addr = {bank, (col_base + tap) mod 2^(ADDR_W-1)}, where bank = nn_layer_cnt[0].
  - wt_addr = tap (zero-extended).
  - tap increments 0..K_eff-1. At wrap: tap=0, col+1, col_base += S_eff.
  - final_column = (col == out_len-1).
  - After the last tap of the last column, go to WAIT.
  - Total rd_vld cycles per layer = cal_cycle exactly.
- Read path timing:
  - Outputs are registered: rd_vld, rd_addr and wt_addr appear 1 cycle after the state/counter update.
  - The first rd_vld is therefore 2 cycles after the parameter handshake.
- wr_bank = ~bank, registered on layer load.
- pe_end handling:
  - pe_end arriving during CAL is latched in pe_seen.
  - In WAIT, (pe_end | pe_seen) advances to NEXT.
  - pe_end in IDLE/LOAD is ignored.
- NEXT:
  - If nn_layer_cnt == lyr_num-1: go to DONE.
  - Else: nn_layer_cnt+1, pulse lyr_done, go to LOAD.
- DONE: pulse all_done for 1 cycle, then go to IDLE. nn_layer_cnt holds its final value.
- abort: in any state, returns to IDLE next cycle.
  - Clears rd_vld, wt_O_vld, pe_seen and the counters.
  - Registered K/S/Pool fields are held.
  - abort has priority over start in the same cycle.
- Arithmetic:
  - col_base is ADDR_W-1 bits and wraps silently.
  - cal_cycle is computed on load as an unsigned product, no saturation.

Test Plan:
1. Reset mid-CAL: assert rst_cal asynchronously -> all outputs 0 and state=0 in the same cycle, without waiting for a clock edge.
2. lyr_num=1, word K=3, S=2, out_len=4, pe_end 5 cycles after CAL ends -> cal_cycle=12.
   - 12 rd_vld cycles with rd_addr 0,1,2,2,3,4,4,5,6,6,7,8 (bank 0).
   - wt_addr cycles 0,1,2.
   - final_column high for the last 3 cycles; single all_done pulse; no lyr_done.
3. lyr_num=3, same words -> lyr_done pulses twice, rd bank sequence 0,1,0, wr_bank 1,0,1; prm_rdy high only in LOAD.
4. pe_end pulsed during CAL -> latched; WAIT exits after 1 cycle with no further pe_end.
5. K=0, S=0, out_len=0 -> treated as 1/1/1: one rd_vld at address 0 and cal_cycle=1.
6. abort asserted during WAIT of layer 2 with a simultaneous start -> IDLE next cycle, busy=0, no all_done; a later start reloads from layer 0.
